// File: rtl/keypad_matrix_scan.sv
`default_nettype none
// ============================================================================
// Module      : keypad_matrix_scan
// Description : 4x4 keypad matrix scanner with tick-paced debounce.
//               Drives one column low at a time, watches the four row lines,
//               confirms a press over two consecutive scan ticks, reports the
//               key once and then holds the column until the key is released
//               (release also confirmed over two ticks).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1  system clock, rising edge
//   rst        in   1  asynchronous reset, active low
//   row_in     in   4  row lines, active low, asynchronous to clk
//   col_out    out  4  column drive, active low, exactly one bit low
//   key_code   out  4  last accepted key {row_idx, col_idx}
//   key_valid  out  1  one-clock pulse when key_code updates
//   key_down   out  1  high while the accepted key is held
// Parameters
//   SCAN_MAX   clock cycles per scan tick (4 .. 2^20-1)
// ============================================================================
module keypad_matrix_scan #(
  parameter logic [19:0] SCAN_MAX = 20'd500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  // --------------------------------------------------------------------------
  // Constants and state encoding
  // --------------------------------------------------------------------------
  localparam logic [3:0]  c_ROWS_IDLE = 4'b1111;
  localparam logic [3:0]  c_COL_RESET = 4'b1110;
  localparam logic [19:0] c_CNT_LAST  = SCAN_MAX - 20'd1;

  typedef enum logic [1:0] {
    ST_SCAN    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_HOLD    = 2'd2,
    ST_REL_CHK = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  // Index of the lowest zero bit of an active-low one-cold vector.
  function automatic logic [1:0] low_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // True when exactly one bit of an active-low vector is asserted.
  function automatic logic one_low(input logic [3:0] v);
    logic [3:0] a;
    a = ~v;
    return (a != 4'd0) && ((a & (a - 4'd1)) == 4'd0);
  endfunction

  // Advance the low column one position: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  function automatic logic [3:0] rotate(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

  // --------------------------------------------------------------------------
  // Registers and next-state wires
  // --------------------------------------------------------------------------
  logic [3:0]  r_row_meta;
  logic [3:0]  r_row_s;
  logic [19:0] r_cnt;
  logic        w_tick;

  state_t      r_state,     w_state_nxt;
  logic [3:0]  r_col,       w_col_nxt;
  logic [3:0]  r_cap_row,   w_cap_row_nxt;
  logic [1:0]  r_cap_col,   w_cap_col_nxt;
  logic [3:0]  r_key_code,  w_key_code_nxt;
  logic        r_key_valid, w_key_valid_nxt;
  logic        r_key_down,  w_key_down_nxt;

  // --------------------------------------------------------------------------
  // Row synchronizer: idle value (all rows high) so reset looks like "no key"
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row_meta <= c_ROWS_IDLE;
      r_row_s    <= c_ROWS_IDLE;
    end else begin
      r_row_meta <= row_in;
      r_row_s    <= r_row_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Free-running scan tick counter, independent of the FSM state
  // --------------------------------------------------------------------------
  assign w_tick = (r_cnt == c_CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= 20'd0;
    end else if (w_tick) begin
      r_cnt <= 20'd0;
    end else begin
      r_cnt <= r_cnt + 20'd1;
    end
  end

  // --------------------------------------------------------------------------
  // FSM state and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_SCAN;
      r_col       <= c_COL_RESET;
      r_cap_row   <= c_ROWS_IDLE;
      r_cap_col   <= 2'd0;
      r_key_code  <= 4'h0;
      r_key_valid <= 1'b0;
      r_key_down  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_col       <= w_col_nxt;
      r_cap_row   <= w_cap_row_nxt;
      r_cap_col   <= w_cap_col_nxt;
      r_key_code  <= w_key_code_nxt;
      r_key_valid <= w_key_valid_nxt;
      r_key_down  <= w_key_down_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state / output logic. Everything holds between ticks; the only
  // output that is not held is key_valid, which is a single-cycle strobe.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_col_nxt       = r_col;
    w_cap_row_nxt   = r_cap_row;
    w_cap_col_nxt   = r_cap_col;
    w_key_code_nxt  = r_key_code;
    w_key_valid_nxt = 1'b0;
    w_key_down_nxt  = r_key_down;

    if (w_tick) begin
      case (r_state)
        ST_SCAN: begin
          if (r_row_s == c_ROWS_IDLE) begin
            w_col_nxt = rotate(r_col);
          end else begin
            // Remember what we saw; the column stays put so the next tick
            // looks at the same key.
            w_cap_row_nxt = r_row_s;
            w_cap_col_nxt = low_idx(r_col);
            w_state_nxt   = ST_CONFIRM;
          end
        end

        ST_CONFIRM: begin
          if ((r_row_s == r_cap_row) && one_low(r_cap_row)) begin
            w_key_code_nxt  = {low_idx(r_cap_row), r_cap_col};
            w_key_valid_nxt = 1'b1;
            w_key_down_nxt  = 1'b1;
            w_state_nxt     = ST_HOLD;
          end else begin
            // Glitch, change or multi-key: drop it and keep scanning.
            w_col_nxt   = rotate(r_col);
            w_state_nxt = ST_SCAN;
          end
        end

        ST_HOLD: begin
          // Column frozen, so keys in other columns are invisible here.
          if (r_row_s == c_ROWS_IDLE) begin
            w_state_nxt = ST_REL_CHK;
          end
        end

        ST_REL_CHK: begin
          if (r_row_s == c_ROWS_IDLE) begin
            w_key_down_nxt = 1'b0;
            w_col_nxt      = rotate(r_col);
            w_state_nxt    = ST_SCAN;
          end else begin
            // Release bounce: the same press continues, no new report.
            w_state_nxt = ST_HOLD;
          end
        end

        default: begin
          w_state_nxt = ST_SCAN;
          w_col_nxt   = c_COL_RESET;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign col_out   = r_col;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_down  = r_key_down;

endmodule
`default_nettype wire

// File: tb/tb_keypad_matrix_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_matrix_scan
// Description : Self-checking bench for keypad_matrix_scan (SCAN_MAX = 8).
//               A physical keypad model turns pressed keys into row levels
//               from the driven column; a tick-level behavioural model of
//               the scanner predicts every output on every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_matrix_scan;

  localparam int SM = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] row_in = 4'hF;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  always #5 clk = ~clk;

  keypad_matrix_scan #(.SCAN_MAX(20'd8)) dut (
    .clk      (clk),
    .rst      (rst),
    .row_in   (row_in),
    .col_out  (col_out),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_down (key_down)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int v_cnt    = 0;     // key_valid pulses seen by the stimulus process
  bit chk_en   = 1'b0;

  // Keypad environment: pressed[r*4+c] closes the switch at row r / col c.
  logic [15:0] pressed   = 16'h0;
  bit          raw_mode  = 1'b0;
  logic [3:0]  raw_rows  = 4'hF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] keypad_rows(input logic [15:0] p, input logic [3:0] col);
    logic [3:0] r;
    r = 4'hF;
    for (int rr = 0; rr < 4; rr++)
      for (int cc = 0; cc < 4; cc++)
        if (p[rr*4+cc] && !col[cc]) r[rr] = 1'b0;
    return r;
  endfunction

  // One clock of stimulus: advance to the falling edge, note any pulse,
  // then let the keypad respond to the column currently driven.
  task automatic step();
    @(negedge clk);
    if (key_valid) v_cnt++;
    row_in = raw_mode ? raw_rows : keypad_rows(pressed, col_out);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic wait_valid(input int max_steps, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_steps && !seen; i++) begin
      step();
      if (key_valid) seen = 1'b1;
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural reference: works at scan-tick granularity with a column
  // number 0..3 and a phase name; row levels are delayed two clocks.
  // --------------------------------------------------------------------------
  localparam int PH_SCAN = 0, PH_CONFIRM = 1, PH_HOLD = 2, PH_REL = 3;

  int         m_cyc = 0;
  int         m_phase = PH_SCAN;
  int         m_col = 0;
  int         m_cap_col = 0;
  logic [3:0] m_cap = 4'hF;
  logic [3:0] m_s1 = 4'hF, m_s2 = 4'hF;
  logic [3:0] m_code = 4'h0;
  logic       m_valid = 1'b0, m_down = 1'b0;

  function automatic int zeros(input logic [3:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) if (!v[i]) n++;
    return n;
  endfunction

  function automatic int first_zero(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (!v[i]) return i;
    return 0;
  endfunction

  function automatic logic [3:0] col_pat(input int i);
    logic [3:0] one;
    one = 4'd1;
    return 4'hF ^ (one << i);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cyc <= 0; m_phase <= PH_SCAN; m_col <= 0; m_cap_col <= 0; m_cap <= 4'hF;
      m_s1 <= 4'hF; m_s2 <= 4'hF; m_code <= 4'h0; m_valid <= 1'b0; m_down <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      if ((m_cyc % SM) == SM - 1) begin
        case (m_phase)
          PH_SCAN:
            if (m_s2 == 4'hF) m_col <= (m_col + 1) % 4;
            else begin m_cap <= m_s2; m_cap_col <= m_col; m_phase <= PH_CONFIRM; end
          PH_CONFIRM:
            if (m_s2 == m_cap && zeros(m_s2) == 1) begin
              m_code  <= 4'(first_zero(m_s2) * 4 + m_cap_col);
              m_valid <= 1'b1;
              m_down  <= 1'b1;
              m_phase <= PH_HOLD;
            end else begin
              m_col <= (m_col + 1) % 4; m_phase <= PH_SCAN;
            end
          PH_HOLD:
            if (m_s2 == 4'hF) m_phase <= PH_REL;
          PH_REL:
            if (m_s2 == 4'hF) begin
              m_down <= 1'b0; m_col <= (m_col + 1) % 4; m_phase <= PH_SCAN;
            end else m_phase <= PH_HOLD;
          default: m_phase <= PH_SCAN;
        endcase
      end
      m_s2  <= m_s1;
      m_s1  <= row_in;
      m_cyc <= m_cyc + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en)
      check("model_outputs", {22'd0, col_out, key_code, key_valid, key_down},
            {22'd0, col_pat(m_col), m_code, m_valid, m_down});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Test sequence
  // --------------------------------------------------------------------------
  typedef struct {
    int         row;
    int         col;
    logic [3:0] code;
    logic [3:0] col_pat;
  } vec_t;

  vec_t       tbl[6];
  logic [3:0] idle_seq[4];

  initial begin : main
    int  v0, trans, misplaced;
    bit  seen;
    logic [3:0] prev;

    tbl[0] = '{2, 1, 4'h9, 4'b1101};
    tbl[1] = '{0, 0, 4'h0, 4'b1110};
    tbl[2] = '{3, 3, 4'hF, 4'b0111};
    tbl[3] = '{1, 2, 4'h6, 4'b1011};
    tbl[4] = '{0, 3, 4'h3, 4'b0111};
    tbl[5] = '{3, 0, 4'hC, 4'b1110};
    idle_seq[0] = 4'b1101; idle_seq[1] = 4'b1011;
    idle_seq[2] = 4'b0111; idle_seq[3] = 4'b1110;

    step();
    chk_en = 1'b1;
    step();

    // Reset values while rst is low
    check("reset_col_out",   {28'd0, col_out},  32'hE);
    check("reset_key_code",  {28'd0, key_code}, 32'h0);
    check("reset_key_valid", {31'd0, key_valid}, 32'h0);
    check("reset_key_down",  {31'd0, key_down},  32'h0);
    rst = 1'b1;

    // Idle scanning: one column step every SM clocks, no key reports
    v0 = v_cnt; trans = 0; misplaced = 0; prev = col_out;
    for (int k = 1; k <= 64; k++) begin
      step();
      if (col_out != prev) begin
        trans++;
        if (k % SM != 0) misplaced++;
      end
      prev = col_out;
      if (k % SM == 0) check("idle_col_seq", {28'd0, col_out}, {28'd0, idle_seq[(k / SM - 1) % 4]});
    end
    check("idle_transitions", trans, 8);
    check("idle_misplaced", misplaced, 0);
    check("idle_no_valid", v_cnt - v0, 0);

    // Table: single presses, one report each, column frozen, clean release
    for (int t = 0; t < 6; t++) begin
      v0 = v_cnt;
      pressed = 16'h0;
      pressed[tbl[t].row * 4 + tbl[t].col] = 1'b1;
      wait_valid(5 * SM + 4, seen);
      check("tbl_latency_seen", {31'd0, seen}, 1);
      check("tbl_code_at_pulse", {28'd0, key_code}, {28'd0, tbl[t].code});
      repeat (4 * SM) step();
      check("tbl_one_pulse", v_cnt - v0, 1);
      check("tbl_col_frozen", {28'd0, col_out}, {28'd0, tbl[t].col_pat});
      check("tbl_down_held", {31'd0, key_down}, 1);
      pressed = 16'h0;
      repeat (3 * SM) step();
      check("tbl_down_released", {31'd0, key_down}, 0);
      check("tbl_code_kept", {28'd0, key_code}, {28'd0, tbl[t].code});
    end

    // Release bounce: released 1 tick, re-pressed, released 2 ticks
    pressed = 16'h0;
    do_reset();
    pressed[2 * 4 + 1] = 1'b1;
    wait_valid(5 * SM + 4, seen);
    check("bounce_first_seen", {31'd0, seen}, 1);
    v0 = v_cnt;
    pressed = 16'h0;
    repeat (SM) step();
    check("bounce_down_after_1", {31'd0, key_down}, 1);
    pressed[2 * 4 + 1] = 1'b1;
    repeat (SM) step();
    check("bounce_down_repress", {31'd0, key_down}, 1);
    pressed = 16'h0;
    repeat (SM) step();
    check("bounce_down_rel_1", {31'd0, key_down}, 1);
    repeat (SM) step();
    check("bounce_down_rel_2", {31'd0, key_down}, 0);
    check("bounce_col_resume", {28'd0, col_out}, 32'hB);
    check("bounce_no_second", v_cnt - v0, 0);

    // One-tick glitch: seen at SCAN, gone at CONFIRM
    v0 = v_cnt;
    raw_mode = 1'b1; raw_rows = 4'b1101;
    repeat (SM) step();
    raw_rows = 4'b1111;
    repeat (SM) step();
    check("glitch_no_valid", v_cnt - v0, 0);
    check("glitch_code_kept", {28'd0, key_code}, 32'h9);
    check("glitch_col_adv", {28'd0, col_out}, 32'h7);
    raw_mode = 1'b0;

    // Two rows low at the CONFIRM tick
    do_reset();
    v0 = v_cnt;
    raw_mode = 1'b1; raw_rows = 4'b1110;
    repeat (SM) step();
    raw_rows = 4'b0011;
    repeat (SM) step();
    check("multi_no_valid", v_cnt - v0, 0);
    check("multi_col_adv", {28'd0, col_out}, 32'hD);
    check("multi_down_low", {31'd0, key_down}, 0);
    raw_mode = 1'b0;

    // Reset while holding a key, key still held afterwards
    do_reset();
    pressed = 16'h0;
    pressed[2 * 4 + 1] = 1'b1;
    wait_valid(5 * SM + 4, seen);
    check("hold_reset_first_seen", {31'd0, seen}, 1);
    repeat (2 * SM) step();
    rst = 1'b0;
    #1;
    check("hold_reset_col",   {28'd0, col_out},  32'hE);
    check("hold_reset_code",  {28'd0, key_code}, 32'h0);
    check("hold_reset_valid", {31'd0, key_valid}, 0);
    check("hold_reset_down",  {31'd0, key_down},  0);
    step();
    step();
    rst = 1'b1;
    wait_valid(5 * SM + 4, seen);
    check("hold_reset_redetect", {31'd0, seen}, 1);
    check("hold_reset_code_again", {28'd0, key_code}, 32'h9);
    pressed = 16'h0;
    repeat (3 * SM) step();

    // Randomized keypad activity; the model checks every cycle
    for (int seg = 0; seg < 150; seg++) begin
      int act, len;
      act = int'($urandom_range(0, 5));
      len = int'($urandom_range(1, 3 * SM));
      raw_mode = 1'b0;
      case (act)
        0: pressed = 16'h0;
        1: begin pressed = 16'h0; pressed[$urandom_range(0, 15)] = 1'b1; len = len + 4 * SM; end
        2: begin pressed = 16'h0; pressed[$urandom_range(0, 15)] = 1'b1; pressed[$urandom_range(0, 15)] = 1'b1; end
        3: begin raw_mode = 1'b1; raw_rows = 4'($urandom_range(0, 15)); end
        4: ;
        default: if ($urandom_range(0, 7) == 0) do_reset();
      endcase
      repeat (len) step();
    end
    raw_mode = 1'b0;
    pressed = 16'h0;
    repeat (4 * SM) step();
    check("random_end_down", {31'd0, key_down}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
